blink_sequencer: RTL and testbench



---
 rtl/blink_pkg.sv | 38 +++
 rtl/rate_divider.sv | 27 ++
 rtl/blink_sequencer.sv | 167 ++++++++++++++++
 tb/tb_blink_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// blink_pkg: shared types and elaboration-time helpers for blink_sequencer.
// Holds the mode/state encodings, the reload-period function and per-mode seeds.
package blink_pkg;

   typedef enum logic [1:0] {
      MODE_UP     = 2'd0,
      MODE_DOWN   = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FILL   = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Pattern value each mode starts from (IDLE, or a mode switch at a strobe).
   localparam int unsigned SEED_UP     = 0;
   localparam int unsigned SEED_DOWN   = 0;
   localparam int unsigned SEED_BOUNCE = 1;
   localparam int unsigned SEED_FILL   = 0;

   // Strobe period in clock cycles for rate index r.
   function automatic int unsigned reload_val(input int unsigned f_clk, input int unsigned r);
      return f_clk / (r + 1);
   endfunction

   function automatic int unsigned mode_seed(input mode_t m);
      case (m)
         MODE_DOWN:   return SEED_DOWN;
         MODE_BOUNCE: return SEED_BOUNCE;
         MODE_FILL:   return SEED_FILL;
         default:     return SEED_UP;
      endcase
   endfunction

endpackage

// File: rtl/rate_divider.sv
// rate_divider: reloadable down-counter shared by every strobe rate.
// Load has priority over run; o_tc flags the terminal (zero) count while running.
module rate_divider #(
   parameter int unsigned       CNT_W   = 27,
   parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_run,
   output logic             o_tc
);

   logic [CNT_W-1:0] r_cnt;

   assign o_tc = i_run && (r_cnt == '0);

   // Counter: reload on request, otherwise count down while running, else hold.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      if (!rst_ni)     r_cnt <= RST_VAL;
      else if (i_load) r_cnt <= i_load_val;
      else if (i_run)  r_cnt <= r_cnt - CNT_W'(1);
   end

endmodule

// File: rtl/blink_sequencer.sv
// blink_sequencer: LED pattern sequencer driven by one scheduled rate divider.
// IDLE/RUN/HOLD FSM; rate and mode changes take effect only at terminal count.
// Optional build macro SEQ_STEP_EN: rising edges of step_i in HOLD single-step
// the pattern. Without it step_i is accepted but ignored.
module blink_sequencer
   import blink_pkg::*;
#(
   parameter int unsigned F_CLK = 66500000,
   parameter int unsigned CNT_W = 27,
   parameter int unsigned LED_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             pause_i,
   input  logic [3:0]       rate_sel_i,
   input  logic [1:0]       mode_i,
   input  logic             step_i,
   output logic             strb_o,
   output logic [1:0]       state_o,
   output logic [LED_W-1:0] led_o
);

   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_RUN  = ST_RUN;
   localparam logic [1:0] S_HOLD = ST_HOLD;

   // The slowest rate must fit the divider, and the fastest must be >= 1 cycle.
   if ((64'(F_CLK) >= (64'd1 << CNT_W)) || (F_CLK < 16)) begin : g_bad_params
      $error("blink_sequencer: need 16 <= F_CLK < 2**CNT_W");
   end

   // Reload-minus-one table, folded to constants at elaboration.
   logic [CNT_W-1:0] w_reload_tbl [16];
   for (genvar g = 0; g < 16; g++) begin : g_reload
      assign w_reload_tbl[g] = CNT_W'(reload_val(F_CLK, g) - 1);
   end

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [LED_W-1:0] r_pat;
   logic             r_dir;
   mode_t            r_mode;
   logic             r_strb;
   mode_t            w_mode_in;
   logic             w_idle_act;
   logic             w_run;
   logic             w_tc;
   logic             w_step;
   logic [LED_W:0]   w_adv;

   // Next pattern for the active mode, returned as {dir, pattern}.
   // dir is the bounce direction (0 = toward MSB) or fill phase (0 = filling).
   function automatic logic [LED_W:0] pat_step(input mode_t mode,
                                               input logic [LED_W-1:0] pat,
                                               input logic dir);
      logic [LED_W-1:0] nxt;
      logic             d;
      nxt = pat;
      d   = dir;
      case (mode)
         MODE_DOWN: nxt = pat - LED_W'(1);
         MODE_BOUNCE: begin
            if (!dir) begin
               if (pat[LED_W-1]) begin nxt = pat >> 1; d = 1'b1; end
               else                    nxt = pat << 1;
            end else begin
               if (pat[0]) begin nxt = pat << 1; d = 1'b0; end
               else              nxt = pat >> 1;
            end
         end
         MODE_FILL: begin
            if (!dir) begin
               if (pat == '1) begin nxt = pat << 1; d = 1'b1; end
               else                 nxt = {pat[LED_W-2:0], 1'b1};
            end else begin
               if (pat == '0) begin nxt = LED_W'(1); d = 1'b0; end
               else                 nxt = pat << 1;
            end
         end
         default: nxt = pat + LED_W'(1);
      endcase
      return {d, nxt};
   endfunction

   assign w_mode_in  = mode_t'(mode_i);
   // en_i low forces IDLE behaviour from any state, so IDLE work happens on the exit edge too.
   assign w_idle_act = (r_state == S_IDLE) || !en_i;
   assign w_run      = (r_state == S_RUN) && en_i;
   assign w_adv      = pat_step(r_mode, r_pat, r_dir);

   rate_divider #(
      .CNT_W   (CNT_W),
      .RST_VAL (CNT_W'(reload_val(F_CLK, 0) - 1))
   ) u_div (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_load     (w_idle_act || w_tc),
      .i_load_val (w_reload_tbl[rate_sel_i]),
      .i_run      (w_run),
      .o_tc       (w_tc)
   );

`ifdef SEQ_STEP_EN
   logic r_step_prev;

   // Previous step_i sample for rising-edge detection.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_step_prev <= 1'b0;
      else         r_step_prev <= step_i;
   end

   assign w_step = (r_state == S_HOLD) && en_i && step_i && !r_step_prev;
`else
   logic w_step_unused;
   assign w_step_unused = step_i;
   assign w_step        = 1'b0;
`endif

   // FSM next state: en_i low wins over pause_i.
   always_comb begin
      // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (en_i) w_state_nxt = S_RUN;
         S_RUN: begin
            if (!en_i)        w_state_nxt = S_IDLE;
            else if (pause_i) w_state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (!en_i)         w_state_nxt = S_IDLE;
            else if (!pause_i) w_state_nxt = S_RUN;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Pattern, mode and strobe: seed in IDLE or on a mode switch at terminal, advance on strobe.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_pat  <= '0;
         r_dir  <= 1'b0;
         r_mode <= MODE_UP;
         r_strb <= 1'b0;
      end else begin
         r_strb <= w_tc || w_step;
         if (w_idle_act || (w_tc && (w_mode_in != r_mode))) begin
            r_mode <= w_mode_in;
            r_pat  <= LED_W'(mode_seed(w_mode_in));
            r_dir  <= 1'b0;
         end else if (w_tc || w_step) begin
            {r_dir, r_pat} <= w_adv;
         end
      end
   end

   assign strb_o  = r_strb;
   assign state_o = r_state;
   assign led_o   = ~r_pat;

endmodule

// File: tb/tb_blink_sequencer.sv
// tb_blink_sequencer: directed scenarios plus randomized run against a
// sequence-index reference model (F_CLK=16, LED_W=8).
module tb_blink_sequencer;

   localparam int F_CLK = 16;
   localparam int CNT_W = 8;
   localparam int LED_W = 8;

   logic             clk_i      = 1'b0;
   logic             rst_ni     = 1'b0;
   logic             en_i       = 1'b0;
   logic             pause_i    = 1'b0;
   logic [3:0]       rate_sel_i = '0;
   logic [1:0]       mode_i     = '0;
   logic             step_i     = 1'b0;
   logic             strb_o;
   logic [1:0]       state_o;
   logic [LED_W-1:0] led_o;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: period P, RUN cycles elapsed e, step index k into the mode's sequence.
   int m_st, m_e, m_p, m_k, m_mode;
   bit m_strb, m_prev_step;

   blink_sequencer #(.F_CLK(F_CLK), .CNT_W(CNT_W), .LED_W(LED_W)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (en_i),
      .pause_i    (pause_i),
      .rate_sel_i (rate_sel_i),
      .mode_i     (mode_i),
      .step_i     (step_i),
      .strb_o     (strb_o),
      .state_o    (state_o),
      .led_o      (led_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // k-th pattern of each mode, written out from the pattern rules.
   function automatic logic [7:0] seq_pat(input int mode, input int k);
      int j;
      case (mode)
         0: return 8'(k);
         1: return 8'(0 - k);
         2: begin
            j = k % 14;
            return (j <= 7) ? 8'(1 << j) : 8'(1 << (14 - j));
         end
         default: begin
            j = k % 16;
            return (j <= 8) ? 8'((1 << j) - 1) : 8'(8'hFF << (j - 8));
         end
      endcase
   endfunction

   task automatic go_idle_model();
      m_p    = F_CLK / (int'(rate_sel_i) + 1);
      m_e    = 0;
      m_mode = int'(mode_i);
      m_k    = 0;
   endtask

   task automatic model_step();
      bit st_edge;
      st_edge = step_i && !m_prev_step;
      m_strb  = 1'b0;
      if (!rst_ni) begin
         m_st = 0; m_e = 0; m_p = F_CLK; m_k = 0; m_mode = 0; m_prev_step = 1'b0;
         return;
      end
      m_prev_step = step_i;
      if (m_st == 0 || !en_i) begin
         m_st = (m_st == 0 && en_i) ? 1 : 0;
         go_idle_model();
      end else if (m_st == 1) begin
         m_e++;
         if (m_e == m_p) begin
            m_strb = 1'b1;
            m_e    = 0;
            m_p    = F_CLK / (int'(rate_sel_i) + 1);
            if (int'(mode_i) != m_mode) begin m_mode = int'(mode_i); m_k = 0; end
            else m_k++;
         end
         if (pause_i) m_st = 2;
      end else begin
`ifdef SEQ_STEP_EN
         if (st_edge) begin m_k++; m_strb = 1'b1; end
`endif
         if (!pause_i) m_st = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      model_step();
      #1;
   endtask

   task automatic wait_strobe(input int budget, output int n, output bit got);
      n = 0; got = 1'b0;
      while (n < budget && !got) begin
         tick();
         n++;
         if (strb_o === 1'b1) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; en_i = 1'b0; rate_sel_i = 4'd0; mode_i = 2'd0;
      repeat (3) tick();
      n_tests++; if (led_o !== 8'hFF) begin n_fail++; $display("FAIL reset_led: got %h want ff", led_o); end
      n_tests++; if (strb_o !== 1'b0) begin n_fail++; $display("FAIL reset_strb: got %b want 0", strb_o); end
      n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
   endtask

   task automatic test_enable();
      int n; bit got;
      logic [7:0] exp_led [3];
      exp_led = '{8'hFE, 8'hFD, 8'hFC};
      rst_ni = 1'b1; en_i = 1'b1;
      // One edge to leave IDLE, then 16 RUN cycles.
      wait_strobe(40, n, got);
      n_tests++; if (!got || n != 17) begin n_fail++; $display("FAIL first_strobe: got %0d cycles (seen=%0b) want 17", n, got); end
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            wait_strobe(40, n, got);
            n_tests++; if (!got || n != 16) begin n_fail++; $display("FAIL r0_period: got %0d want 16", n); end
         end
         n_tests++; if (led_o !== exp_led[i]) begin n_fail++; $display("FAIL up_led%0d: got %h want %h", i, led_o, exp_led[i]); end
      end
      tick();
      n_tests++; if (strb_o !== 1'b0) begin n_fail++; $display("FAIL strobe_width: got %b want 0", strb_o); end
   endtask

   task automatic test_rate_change();
      int n; bit got;
      int exp_n [3];
      exp_n = '{11, 4, 4};
      wait_strobe(40, n, got);
      repeat (5) tick();
      rate_sel_i = 4'd3;
      for (int i = 0; i < 3; i++) begin
         wait_strobe(40, n, got);
         n_tests++; if (!got || n != exp_n[i]) begin n_fail++; $display("FAIL rate_change%0d: got %0d want %0d", i, n, exp_n[i]); end
      end
   endtask

   task automatic test_bounce();
      int n; bit got;
      logic [7:0] exp_pat [16];
      exp_pat = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      mode_i = 2'd2;
      for (int i = 0; i < 16; i++) begin
         wait_strobe(40, n, got);
         n_tests++; if (!got || led_o !== ~exp_pat[i]) begin n_fail++; $display("FAIL bounce%0d: got %h want %h", i, led_o, ~exp_pat[i]); end
      end
   endtask

   task automatic test_pause();
      int n; bit got;
      logic [7:0] held;
      mode_i = 2'd0; rate_sel_i = 4'd0;
      wait_strobe(40, n, got);
      repeat (6) tick();
      pause_i = 1'b1;
      tick();
      held = led_o;
      n_tests++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL pause_state: got %0d want 2", state_o); end
      for (int i = 0; i < 19; i++) begin
         tick();
         n_tests++; if (strb_o !== 1'b0 || state_o !== 2'd2 || led_o !== held) begin
            n_fail++; $display("FAIL hold%0d: strb %b state %0d led %h want 0/2/%h", i, strb_o, state_o, led_o, held);
         end
      end
      pause_i = 1'b0;
      tick();
      n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL resume_state: got %0d want 1", state_o); end
      wait_strobe(40, n, got);
      n_tests++; if (!got || n != 9) begin n_fail++; $display("FAIL resume_strobe: got %0d want 9", n); end
      n_tests++; if (led_o !== ~seq_pat(m_mode, m_k)) begin n_fail++; $display("FAIL resume_led: got %h want %h", led_o, ~seq_pat(m_mode, m_k)); end
   endtask

   task automatic test_simultaneous();
      int n; bit got;
      // pause_i rises on the terminal cycle
      repeat (15) tick();
      pause_i = 1'b1;
      tick();
      n_tests++; if (strb_o !== 1'b1 || state_o !== 2'd2) begin n_fail++; $display("FAIL pause_at_tc: strb %b state %0d want 1/2", strb_o, state_o); end
      tick();
      n_tests++; if (strb_o !== 1'b0) begin n_fail++; $display("FAIL pause_at_tc_after: got %b want 0", strb_o); end
      pause_i = 1'b0;
      tick();
      // en_i falls on the terminal cycle
      repeat (15) tick();
      en_i = 1'b0;
      tick();
      n_tests++; if (strb_o !== 1'b0 || state_o !== 2'd0 || led_o !== 8'hFF) begin
         n_fail++; $display("FAIL en_fall_at_tc: strb %b state %0d led %h want 0/0/ff", strb_o, state_o, led_o);
      end
      // reset in mid-RUN, on what would be the terminal cycle
      en_i = 1'b1; mode_i = 2'd1;
      wait_strobe(40, n, got);
      n_tests++; if (!got || led_o !== 8'h00) begin n_fail++; $display("FAIL down_first: got %h want 00", led_o); end
      repeat (15) tick();
      rst_ni = 1'b0;
      tick();
      n_tests++; if (strb_o !== 1'b0 || state_o !== 2'd0 || led_o !== 8'hFF) begin
         n_fail++; $display("FAIL mid_run_reset: strb %b state %0d led %h want 0/0/ff", strb_o, state_o, led_o);
      end
      rst_ni = 1'b1; en_i = 1'b0;
   endtask

   task automatic test_step();
      logic [7:0] exp_pat [3];
      bit         exp_strb;
`ifdef SEQ_STEP_EN
      exp_pat  = '{8'h01, 8'h03, 8'h07};
      exp_strb = 1'b1;
`else
      exp_pat  = '{8'h00, 8'h00, 8'h00};
      exp_strb = 1'b0;
`endif
      mode_i = 2'd3; rate_sel_i = 4'd3;
      tick();
      en_i = 1'b1; pause_i = 1'b1;
      repeat (2) tick();
      n_tests++; if (state_o !== 2'd2 || led_o !== 8'hFF) begin n_fail++; $display("FAIL step_hold: state %0d led %h want 2/ff", state_o, led_o); end
      for (int i = 0; i < 3; i++) begin
         step_i = 1'b1;
         tick();
         n_tests++; if (strb_o !== exp_strb || led_o !== ~exp_pat[i]) begin
            n_fail++; $display("FAIL step%0d: strb %b led %h want %b/%h", i, strb_o, led_o, exp_strb, ~exp_pat[i]);
         end
         tick();
         n_tests++; if (strb_o !== 1'b0 || led_o !== ~exp_pat[i]) begin
            n_fail++; $display("FAIL step%0d_level: strb %b led %h want 0/%h", i, strb_o, led_o, ~exp_pat[i]);
         end
         step_i = 1'b0;
         repeat (2) tick();
      end
      pause_i = 1'b0;
   endtask

   task automatic test_random();
      logic [7:0] exp_led;
      rst_ni = 1'b0;
      tick();
      rst_ni = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         rst_ni = ($urandom_range(0, 999) >= 3);
         en_i   = ($urandom_range(0, 99) >= 3);
         if ($urandom_range(0, 99) < 3) pause_i = ~pause_i;
         if ($urandom_range(0, 99) < 2) rate_sel_i = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 99) < 3) mode_i = 2'($urandom_range(0, 3));
         step_i = ($urandom_range(0, 99) < 30);
         tick();
         exp_led = ~seq_pat(m_mode, m_k);
         n_tests++; if (strb_o !== m_strb) begin n_fail++; $display("FAIL rnd_strb@%0d: got %b want %b", c, strb_o, m_strb); end
         n_tests++; if (state_o !== 2'(m_st)) begin n_fail++; $display("FAIL rnd_state@%0d: got %0d want %0d", c, state_o, m_st); end
         n_tests++; if (led_o !== exp_led) begin n_fail++; $display("FAIL rnd_led@%0d: got %h want %h", c, led_o, exp_led); end
      end
   endtask

   initial begin
      test_reset();
      test_enable();
      test_rate_change();
      test_bounce();
      test_pause();
      test_simultaneous();
      test_step();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
